// File: rtl/clk_gen_multi_pkg.sv
// rtl/clk_gen_multi_pkg.sv - shared types and configuration legality check for clk_gen_multi
//
// Package clk_gen_pkg. It is imported by clk_gen_multi_if, clk_gen_chan and clk_gen_multi.
//   cnt_t        : default-width counter word (CNT_W_DEF bits)
//   chan_state_e : per-channel FSM states IDLE / PHASE / RUN
//   cfg_s        : {period, high, phase} at the default counter width
//   cfg_legal()  : returns 1 when a configuration may be accepted
// The optional macro CLK_GEN_GLITCHLESS_STOP_EN is not used in this file.

package clk_gen_pkg;

  localparam int CNT_W_DEF = 16;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PHASE = 2'd1,
    RUN   = 2'd2
  } chan_state_e;

  typedef struct packed {
    cnt_t period;
    cnt_t high;
    cnt_t phase;
  } cfg_s;

  // The arguments are zero-extended to 32 bits so that one function serves
  // every counter width up to 32 bits.
  function automatic logic cfg_legal(input int unsigned period,
                                     input int unsigned high,
                                     input int unsigned phase,
                                     input int unsigned ch,
                                     input int unsigned num_ch);
    return (period >= 32'd2) && (high != 32'd0) && (high < period) &&
           (phase < period) && (ch < num_ch);
  endfunction

endpackage

// File: rtl/clk_gen_multi_if.sv
// rtl/clk_gen_multi_if.sv - configuration handshake interface for clk_gen_multi
//
// Signals:
//   cfg_valid  : configuration write request       (master -> slave)
//   cfg_ready  : the addressed channel can accept   (slave -> master)
//   cfg_ch     : target channel, width at least 1   (master -> slave)
//   cfg_period : period in system-clock cycles      (master -> slave)
//   cfg_high   : high time in system-clock cycles   (master -> slave)
//   cfg_phase  : delay from enable to first rise    (master -> slave)
//   cfg_err    : one-cycle illegal-config pulse     (slave -> master)
// The optional macro CLK_GEN_GLITCHLESS_STOP_EN is not used in this file.

interface clk_gen_multi_if
  import clk_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEF
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_high;
  logic [CNT_W-1:0] cfg_phase;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_period, cfg_high, cfg_phase,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_period, cfg_high, cfg_phase,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/clk_gen_multi_chan.sv
// rtl/clk_gen_multi_chan.sv - one divided-clock channel: FSM, counter, active/shadow config
//
// Module clk_gen_chan.
// Ports:
//   clk, rst_n       : system clock, synchronous active-low reset
//   enable           : level-sensitive run request
//   wr_en            : accepted legal configuration addressed to this channel
//   wr_period/high/phase : the configuration being written
//   pending          : a shadow configuration is waiting for a period boundary
//   clk_out          : generated clock, registered
//   rise_pulse       : high in the cycle clk_out goes 0->1
// Macro CLK_GEN_GLITCHLESS_STOP_EN: when defined, dropping enable during a
// high time lets that high time finish before the channel goes idle.

module clk_gen_chan
  import clk_gen_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int DEF_PERIOD = 10,
  parameter int DEF_HIGH   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_period,
  input  logic [CNT_W-1:0] wr_high,
  input  logic [CNT_W-1:0] wr_phase,
  output logic             pending,
  output logic             clk_out,
  output logic             rise_pulse
);

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
    logic [CNT_W-1:0] phase;
  } chan_cfg_t;

  localparam chan_cfg_t CFG_RST = {CNT_W'(DEF_PERIOD), CNT_W'(DEF_HIGH), {CNT_W{1'b0}}};

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  chan_cfg_t        act_q, act_d;
  chan_cfg_t        shd_q, shd_d;
  logic             pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             rise_q, rise_d;

  chan_cfg_t        wr_cfg;
  logic [CNT_W-1:0] idle_period;
  logic [CNT_W-1:0] idle_phase;
  logic [CNT_W-1:0] cnt_inc;
  logic             boundary;
  logic             keep_high;
  logic             commit;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    act_d     = act_q;
    shd_d     = shd_q;
    pend_d    = pend_q;
    commit    = 1'b0;
    wr_cfg    = {wr_period, wr_high, wr_phase};
    // A write that lands while idle is already the active config, so a
    // simultaneous enable starts from the new values.
    idle_period = wr_en ? wr_period : act_q.period;
    idle_phase  = wr_en ? wr_phase  : act_q.phase;
    cnt_inc   = cnt_q + 1'b1;
    boundary  = (state_q == RUN) && (cnt_q == act_q.period - 1'b1);
`ifdef CLK_GEN_GLITCHLESS_STOP_EN
    // Still inside a high time that has not reached its end.
    keep_high = !boundary && (cnt_inc < act_q.high);
`else
    keep_high = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable) begin
          // RUN is entered at the last count of a virtual period, so the
          // first rise always comes one edge after the counter is set up.
          if (idle_phase == '0) begin
            state_d = RUN;
            cnt_d   = idle_period - 1'b1;
          end else begin
            state_d = PHASE;
            cnt_d   = idle_phase - 1'b1;
          end
        end
      end

      PHASE: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
          commit  = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = RUN;
          cnt_d   = act_q.period - 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      RUN: begin
        if (enable || keep_high) begin
          if (boundary) begin
            cnt_d  = '0;
            commit = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          commit  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // The old shadow commits before a same-cycle write is considered.
    if (commit && pend_q) begin
      act_d  = shd_q;
      pend_d = 1'b0;
    end

    if (wr_en) begin
      if ((state_q == IDLE) || (state_d == IDLE)) begin
        act_d = wr_cfg;
      end else begin
        shd_d  = wr_cfg;
        pend_d = 1'b1;
      end
    end

    // The output is high only while counting inside RUN. The RUN entry cycle
    // always gives 0.
    clk_out_d = (state_q == RUN) && (state_d == RUN) && (cnt_d < act_d.high);
    rise_d    = clk_out_d && !clk_out_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      act_q     <= CFG_RST;
      shd_q     <= CFG_RST;
      pend_q    <= 1'b0;
      clk_out_q <= 1'b0;
      rise_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      act_q     <= act_d;
      shd_q     <= shd_d;
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      rise_q    <= rise_d;
    end
  end

  assign pending    = pend_q;
  assign clk_out    = clk_out_q;
  assign rise_pulse = rise_q;

endmodule

// File: rtl/clk_gen_multi.sv
// rtl/clk_gen_multi.sv - NUM_CH independent programmable divided clocks from the system clock
//
// Module clk_gen_multi (top).
// Ports:
//   clk, rst_n  : system clock, synchronous active-low reset
//   cfg         : clk_gen_multi_if.slave configuration handshake
//                 (valid/ready/ch/period/high/phase/err)
//   enable      : per-channel level-sensitive run request
//   clk_out     : per-channel generated clocks, registered
//   rise_pulse  : per-channel one-cycle strobe on each 0->1 of clk_out
// Macro CLK_GEN_GLITCHLESS_STOP_EN: when defined, each channel finishes its
// current high time after enable drops, then goes idle.

module clk_gen_multi
  import clk_gen_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int DEF_PERIOD = 10,
  parameter int DEF_HIGH   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  clk_gen_multi_if.slave    cfg,
  input  logic [NUM_CH-1:0] enable,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] rise_pulse
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]      pending;
  logic [NUM_CH-1:0]      wr_en;
  logic [(1<<CH_W)-1:0]   pending_pad;
  logic                   fire;
  logic                   legal;
  logic                   cfg_err_d, cfg_err_q;

  // Channel numbers beyond NUM_CH read as not pending. They always handshake,
  // so the illegal channel number is reported through cfg_err.
  always_comb begin
    pending_pad             = '0;
    pending_pad[NUM_CH-1:0] = pending;
  end

  assign cfg.cfg_ready = ~pending_pad[cfg.cfg_ch];
  assign fire          = cfg.cfg_valid & cfg.cfg_ready;
  assign legal         = cfg_legal(32'(cfg.cfg_period), 32'(cfg.cfg_high),
                                   32'(cfg.cfg_phase), 32'(cfg.cfg_ch), 32'(NUM_CH));
  assign cfg_err_d     = fire & ~legal;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg.cfg_err = cfg_err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_en[i] = fire & legal & (cfg.cfg_ch == CH_W'(i));

    clk_gen_chan #(
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD),
      .DEF_HIGH   (DEF_HIGH)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable[i]),
      .wr_en      (wr_en[i]),
      .wr_period  (cfg.cfg_period),
      .wr_high    (cfg.cfg_high),
      .wr_phase   (cfg.cfg_phase),
      .pending    (pending[i]),
      .clk_out    (clk_out[i]),
      .rise_pulse (rise_pulse[i])
    );
  end

endmodule

// File: tb/tb_clk_gen_multi.sv
// tb/tb_clk_gen_multi.sv - self-checking bench for clk_gen_multi against a timeline reference model
//
// The model tracks, for each channel, the edge at which the current period
// began rising, and derives clk_out from edge arithmetic.
// Macro CLK_GEN_GLITCHLESS_STOP_EN selects the matching stop rule in the model.

module tb_clk_gen_multi;
  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 2;
  localparam int DEF_P  = 10;
  localparam int DEF_H  = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] enable = '0;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] rise_pulse;

  clk_gen_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) cfg_if ();

  clk_gen_multi #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_PERIOD(DEF_P), .DEF_HIGH(DEF_H)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg(cfg_if), .enable(enable),
    .clk_out(clk_out), .rise_pulse(rise_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int t = 0;

  bit m_run [NUM_CH];
  int m_start [NUM_CH];
  int a_p [NUM_CH], a_h [NUM_CH], a_ph [NUM_CH];
  int s_p [NUM_CH], s_h [NUM_CH], s_ph [NUM_CH];
  bit m_pend [NUM_CH];
  bit m_out [NUM_CH];
  bit m_rise [NUM_CH];
  bit m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_run[i] = 0; m_out[i] = 0; m_rise[i] = 0; m_pend[i] = 0; m_start[i] = 0;
      a_p[i] = DEF_P; a_h[i] = DEF_H; a_ph[i] = 0;
      s_p[i] = DEF_P; s_h[i] = DEF_H; s_ph[i] = 0;
    end
    m_err = 0;
  endtask

  function automatic bit model_ready(input int ch);
    return (ch >= NUM_CH) ? 1'b1 : !m_pend[ch];
  endfunction

  task automatic commit_shadow(input int i);
    if (m_pend[i]) begin
      a_p[i] = s_p[i]; a_h[i] = s_h[i]; a_ph[i] = s_ph[i]; m_pend[i] = 0;
    end
  endtask

  // One rising edge of the reference model, using the inputs that the edge samples.
  task automatic model_edge();
    int ch, p, h, ph;
    bit fire, legal;
    ch = int'(cfg_if.cfg_ch);
    p  = int'(cfg_if.cfg_period);
    h  = int'(cfg_if.cfg_high);
    ph = int'(cfg_if.cfg_phase);
    fire  = cfg_if.cfg_valid && model_ready(ch);
    legal = (p >= 2) && (h != 0) && (h < p) && (ph < p) && (ch < NUM_CH);
    m_err = fire && !legal;
    for (int i = 0; i < NUM_CH; i++) begin
      bit wr, prev, go, first, wrap;
      wr   = fire && legal && (ch == i);
      prev = m_out[i];
      if (!m_run[i]) begin
        if (wr) begin a_p[i] = p; a_h[i] = h; a_ph[i] = ph; end
        if (enable[i]) begin m_run[i] = 1; m_start[i] = t + 1 + a_ph[i]; end
        m_out[i] = 0;
      end else begin
        first = (t == m_start[i]);
        wrap  = (t - m_start[i] == a_p[i]);
        go    = enable[i];
`ifdef CLK_GEN_GLITCHLESS_STOP_EN
        if (!enable[i] && (t > m_start[i]) && (t - m_start[i] < a_h[i])) go = 1;
`endif
        if (!go) begin
          m_run[i] = 0; m_out[i] = 0;
          commit_shadow(i);
          if (wr) begin a_p[i] = p; a_h[i] = h; a_ph[i] = ph; end
        end else begin
          if (first || wrap) begin
            if (wrap) m_start[i] = t;
            commit_shadow(i);
          end
          m_out[i] = (t >= m_start[i]) && (t - m_start[i] < a_h[i]);
          if (wr) begin s_p[i] = p; s_h[i] = h; s_ph[i] = ph; m_pend[i] = 1; end
        end
      end
      m_rise[i] = m_out[i] && !prev;
    end
  endtask

  task automatic tick();
    #1;
    check("cfg_ready", cfg_if.cfg_ready, model_ready(int'(cfg_if.cfg_ch)));
    @(posedge clk);
    t++;
    if (!rst_n) m_reset();
    else model_edge();
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      check($sformatf("clk_out[%0d]", i), clk_out[i], m_out[i]);
      check($sformatf("rise_pulse[%0d]", i), rise_pulse[i], m_rise[i]);
    end
    check("cfg_err", cfg_if.cfg_err, m_err);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic cfg_write(input int ch, input int p, input int h, input int ph);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_ch     = CH_W'(ch);
    cfg_if.cfg_period = CNT_W'(p);
    cfg_if.cfg_high   = CNT_W'(h);
    cfg_if.cfg_phase  = CNT_W'(ph);
    tick();
    cfg_if.cfg_valid  = 1'b0;
  endtask

  initial begin
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = '0;
    cfg_if.cfg_period = '0; cfg_if.cfg_high = '0; cfg_if.cfg_phase = '0;
    rst_n = 1'b0;
    @(posedge clk); t++;
    @(posedge clk); t++;
    #1;
    m_reset();
    check("reset clk_out", 32'(clk_out), 32'd0);
    check("reset rise_pulse", 32'(rise_pulse), 32'd0);
    check("reset cfg_err", 32'(cfg_if.cfg_err), 32'd0);
    check("reset cfg_ready", 32'(cfg_if.cfg_ready), 32'd1);
    rst_n = 1'b1;
    ticks(2);

    // Defaults on channel 0.
    enable[0] = 1'b1;
    ticks(25);

    // Phase offset on channel 1.
    cfg_write(1, 8, 2, 3);
    enable[1] = 1'b1;
    ticks(30);

    // Runtime update on channel 0, issued mid-period.
    for (int n = 0; n < 12 && ((t - m_start[0]) % a_p[0]) != 3; n++) tick();
    cfg_write(0, 4, 1, 0);
    ticks(25);

    // Illegal configurations.
    cfg_write(1, 1, 1, 0);  tick();
    cfg_write(1, 8, 0, 0);  tick();
    cfg_write(1, 8, 8, 0);  tick();
    cfg_write(1, 8, 2, 8);  tick();
    cfg_write(3, 8, 2, 0);  tick();
    ticks(10);

    // Stop channel 2 during its second high cycle.
    cfg_write(2, 6, 4, 0);
    enable[2] = 1'b1;
    tick();
    for (int n = 0; n < 20 && t < m_start[2] + 1; n++) tick();
    check("ch2 high before stop", 32'(clk_out[2]), 32'd1);
    enable[2] = 1'b0;
    ticks(8);

    // Reset mid-run with every channel enabled.
    enable = '1;
    ticks(12);
    rst_n = 1'b0;
    tick();
    check("midrun reset clk_out", 32'(clk_out), 32'd0);
    rst_n = 1'b1;
    ticks(25);

    // Randomised traffic.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NUM_CH; i++)
        if ($urandom_range(0, 24) == 0) enable[i] = ~enable[i];
      if ($urandom_range(0, 4) == 0) begin
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_ch     = CH_W'($urandom_range(0, 3));
        cfg_if.cfg_period = CNT_W'($urandom_range(0, 12));
        cfg_if.cfg_high   = CNT_W'($urandom_range(0, 12));
        cfg_if.cfg_phase  = CNT_W'($urandom_range(0, 12));
      end else begin
        cfg_if.cfg_valid = 1'b0;
      end
      rst_n = ($urandom_range(0, 599) != 0);
      tick();
    end
    rst_n = 1'b1;
    cfg_if.cfg_valid = 1'b0;
    ticks(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_gen_multi.md
Name: clk_gen_multi

Overview:
- Synthesizable, parametrised successor to the behavioural frequency/duty/phase clock generator.
- Derives NUM_CH independent divided clocks from the single 100 MHz system clock.
- Each channel has a runtime-programmable period, high time and phase offset, all counted in system-clock cycles.
- Used as the on-chip stimulus/strobe source for bench and FPGA bring-up; replaces the task-based generators.

Parameters:
- NUM_CH, 4, number of independent output channels (1..16).
- CNT_W, 16, width of the period/high/phase counters; maximum period is 2^CNT_W-1 cycles.
- DEF_PERIOD, 10, per-channel period loaded at reset.
- DEF_HIGH, 5, per-channel high time loaded at reset.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cfg_valid  in  1  configuration write request.
- cfg_ready  out  1  configuration can be accepted for cfg_ch.
- cfg_ch  in  $clog2(NUM_CH)  target channel (width minimum 1).
- cfg_period  in  CNT_W  period in cycles.
- cfg_high  in  CNT_W  high time in cycles.
- cfg_phase  in  CNT_W  delay from enable to the first rising edge.
- cfg_err  out  1  one-cycle pulse when a handshake carries an illegal configuration.
- enable  in  NUM_CH  per-channel run request, level sensitive.
- clk_out  out  NUM_CH  generated clocks, registered.
- rise_pulse  out  NUM_CH  one-cycle strobe in the same cycle clk_out[i] goes 0->1.

Behaviour:
- Reset (rst_n=0 at an edge):
  - clk_out=0, rise_pulse=0, cfg_err=0.
  - All channels IDLE, pending flags cleared.
  - Active and shadow registers = {DEF_PERIOD, DEF_HIGH, 0}.
  - cfg_ready=1 after reset.
  - Reset mid-run stops the output at the next edge, with no partial high time.
- Handshake:
  - A transfer occurs on cfg_valid & cfg_ready.
  - cfg_ready = ~pending[cfg_ch], combinational on cfg_ch.
- Legality check: a configuration is illegal if any of these hold:
  - cfg_period < 2
  - cfg_high == 0
  - cfg_high >= cfg_period
  - cfg_phase >= cfg_period
  - cfg_ch >= NUM_CH
- Illegal configuration: cfg_err=1 for the next cycle only; no register changes.
- Legal configuration:
  - Channel IDLE: written directly to the active registers.
  - Channel PHASE/RUN: written to the shadow and pending set. At the next period boundary (cnt == period-1 in RUN) shadow is copied to active and pending cleared. The phase field is ignored until the next IDLE->PHASE entry.
- Channel FSM, states IDLE, PHASE, RUN:
  - IDLE: cnt=0, clk_out=0. enable[i]=1 sampled at edge k: if phase==0 go RUN with cnt=0 and clk_out=1 at edge k+1; else go PHASE with cnt=phase-1.
  - PHASE: cnt decrements each cycle; at cnt==0 go RUN; clk_out rises one edge later. First rise is at edge k+1+phase.
  - RUN: cnt counts 0..period-1 and wraps. clk_out registered as (next cnt < high). Output is high for `high` cycles and low for `period-high` cycles.
- enable[i] drops while in PHASE or RUN: at the next edge clk_out=0, state IDLE, and the pending shadow is applied immediately.
- rise_pulse[i]=1 exactly in the cycles where clk_out[i] transitions 0->1.
- Channels are fully independent; simultaneous enables give edge-aligned outputs when phases are equal.
- Config and boundary on the same cycle: the old shadow commits first; the new write becomes pending.

Optional Feature:
- Macro: CLK_GEN_GLITCHLESS_STOP_EN.
- Defined: an enable drop during a high time lets that high time complete (clk_out stays 1 until the cnt reaches high), then goes IDLE. Minimum pulse width is always honoured.
- Undefined: immediate stop as described in Behaviour.

Decomposition:
- Package clk_gen_pkg:
  - cnt_t (logic [CNT_W-1:0], via parameterised typedef or package localparam)
  - chan_state_e {IDLE, PHASE, RUN}
  - cfg_s {period, high, phase}
  - function cfg_legal()
- Sub-module clk_gen_chan: one channel FSM, counter, and active/shadow registers.
- Top clk_gen_multi: generates NUM_CH instances and adds handshake decode, cfg_ready mux and cfg_err register.

Test Plan:
- Reset defaults: enable[0]=1 after reset -> clk_out[0] period 10 cycles, 5 high; first rise 1 edge after enable is sampled.
- Phase: cfg ch1 {period 8, high 2, phase 3}, enable[1] -> first rise at edge k+4, then 2 high / 6 low repeating; rise_pulse[1] aligned with each rise.
- Runtime update: ch0 running at {10,5}, write {4,1} mid-period -> cfg_ready low until the boundary. The old period finishes intact, then 1 high / 3 low.
- Illegal configs: {period 1}, {high 0}, {high=period}, {phase=period}, cfg_ch=NUM_CH -> cfg_err pulses 1 cycle each; outputs are unchanged.
- Stop: disable ch2 in the second high cycle of {6,4} -> clk_out[2]=0 next edge. With CLK_GEN_GLITCHLESS_STOP_EN: stays high 2 more cycles, then 0.
- rst_n=0 for one cycle mid-run on all channels -> all clk_out=0 next edge and configs return to defaults.
